// File: rtl/mdio_master.sv
// mdio_master: IEEE 802.3 clause 22 MDIO frame engine.
// Turns one-cycle read/write requests into MDC/MDIO frames and returns read data.
// MDC runs at clock/2 while a frame is in progress and is held low otherwise.
// Optional feature macro: MDIO_TA_CHECK_EN adds rd_error, which flags a read whose
// second turnaround bit came back high (no PHY pulling the line low).
module mdio_master #(
    parameter logic [4:0]  PHY_ADDR     = 5'h00,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter int unsigned IDLE_BITS    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  addr,
    input  logic        rd_request,
    input  logic        wr_request,
    input  logic [15:0] wr_data,
    output logic        ready,
    output logic [15:0] rd_data,
    inout  wire         mdio_pin,
    output logic        mdc_pin
`ifdef MDIO_TA_CHECK_EN
    ,
    output logic        rd_error
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StHdr,
        StTa,
        StData,
        StGap
    } state_e;

    // Counter reload values; each state counts its bits down to zero.
    localparam logic [5:0] PreLast  = 6'(PREAMBLE_LEN - 1);
    localparam logic [5:0] HdrLast  = 6'd13;
    localparam logic [5:0] TaLast   = 6'd1;
    localparam logic [5:0] DataLast = 6'd15;
    // The gap holds MDC low, so it is counted in clocks rather than MDC periods.
    localparam logic [5:0] GapLast  = 6'((IDLE_BITS * 2) - 1);
    localparam bit         HasGap   = (IDLE_BITS != 0);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        mdc_q, mdc_d;
    logic        op_rd_q, op_rd_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] rd_data_q, rd_data_d;
`ifdef MDIO_TA_CHECK_EN
    logic        ta_bit_q, ta_bit_d;
    logic        rd_error_q, rd_error_d;
`endif

    logic        mdio_oe;
    logic        mdio_out;
    logic [13:0] hdr;

    // ST, OP, PHYAD, REGAD sent msb first while in the header state.
    assign hdr = {2'b01, (op_rd_q ? 2'b10 : 2'b01), PHY_ADDR, addr_q};

    // State register with synchronous active-low reset; reset aborts any frame.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mdc_q      <= 1'b0;
            op_rd_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            rd_data_q  <= '0;
`ifdef MDIO_TA_CHECK_EN
            ta_bit_q   <= 1'b0;
            rd_error_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mdc_q      <= mdc_d;
            op_rd_q    <= op_rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            shift_q    <= shift_d;
            rd_data_q  <= rd_data_d;
`ifdef MDIO_TA_CHECK_EN
            ta_bit_q   <= ta_bit_d;
            rd_error_q <= rd_error_d;
`endif
        end
    end

    // Next-state logic. A bit advances on the edge that drives MDC low (mdc_q=1)
    // and MDIO is sampled on the edge that drives MDC high (mdc_q=0).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mdc_d      = 1'b0;
        op_rd_d    = op_rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        shift_d    = shift_q;
        rd_data_d  = rd_data_q;
`ifdef MDIO_TA_CHECK_EN
        ta_bit_d   = ta_bit_q;
        rd_error_d = rd_error_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (rd_request || wr_request) begin
                    state_d = StPre;
                    cnt_d   = PreLast;
                    // Read wins when both requests arrive together.
                    op_rd_d = rd_request;
                    addr_d  = addr;
                    wdata_d = wr_data;
                end
            end
            StPre: begin
                mdc_d = ~mdc_q;
                if (mdc_q) begin
                    if (cnt_q == 6'd0) begin
                        state_d = StHdr;
                        cnt_d   = HdrLast;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StHdr: begin
                mdc_d = ~mdc_q;
                if (mdc_q) begin
                    if (cnt_q == 6'd0) begin
                        state_d = StTa;
                        cnt_d   = TaLast;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StTa: begin
                mdc_d = ~mdc_q;
`ifdef MDIO_TA_CHECK_EN
                // Second TA bit: a present PHY pulls the line low here.
                if (!mdc_q && (cnt_q == 6'd0)) begin
                    ta_bit_d = mdio_pin;
                end
`endif
                if (mdc_q) begin
                    if (cnt_q == 6'd0) begin
                        state_d = StData;
                        cnt_d   = DataLast;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StData: begin
                mdc_d = ~mdc_q;
                if (!mdc_q) begin
                    shift_d = {shift_q[14:0], mdio_pin};
                end
                if (mdc_q) begin
                    if (cnt_q == 6'd0) begin
                        state_d = HasGap ? StGap : StIdle;
                        cnt_d   = GapLast;
                        if (op_rd_q) begin
`ifdef MDIO_TA_CHECK_EN
                            rd_error_d = ta_bit_q;
                            if (!ta_bit_q) begin
                                rd_data_d = shift_q;
                            end
`else
                            rd_data_d = shift_q;
`endif
                        end
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
            end
            StGap: begin
                if (cnt_q == 6'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // MDIO drive: decoded from registered state so it only moves on MDC-low edges.
    always_comb begin
        mdio_oe  = 1'b0;
        mdio_out = 1'b1;
        unique case (state_q)
            StPre: begin
                mdio_oe  = 1'b1;
                mdio_out = 1'b1;
            end
            StHdr: begin
                mdio_oe  = 1'b1;
                mdio_out = hdr[cnt_q[3:0]];
            end
            StTa: begin
                // Write drives 1 then 0; read leaves the line to the PHY.
                mdio_oe  = ~op_rd_q;
                mdio_out = cnt_q[0];
            end
            StData: begin
                mdio_oe  = ~op_rd_q;
                mdio_out = wdata_q[cnt_q[3:0]];
            end
            default: begin
                mdio_oe  = 1'b0;
                mdio_out = 1'b1;
            end
        endcase
    end

    assign mdio_pin = mdio_oe ? mdio_out : 1'bz;
    assign mdc_pin  = mdc_q;
    assign rd_data  = rd_data_q;
    // Drops in the same cycle a request is seen so one request yields one accept.
    assign ready    = (state_q == StIdle) & ~rd_request & ~wr_request & reset_n;
`ifdef MDIO_TA_CHECK_EN
    assign rd_error = rd_error_q;
`endif

endmodule

// File: tb/tb_mdio_master.sv
// tb_mdio_master: directed self-checking bench for mdio_master.
// Walks every frame bit by bit, checking MDC phase, MDIO drive/value and ready,
// with a simple PHY model that answers read frames. Honours MDIO_TA_CHECK_EN.
`timescale 1ns / 1ps
module tb_mdio_master;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [4:0]  addr;
    logic        rd_request;
    logic        wr_request;
    logic [15:0] wr_data;
    logic        ready;
    logic [15:0] rd_data;
    logic        mdc;
    wire         mdio;
    logic        phy_en;
    logic        phy_val;
`ifdef MDIO_TA_CHECK_EN
    logic        rd_error;
`endif

    int checks   = 0;
    int failures = 0;

    pullup (mdio);
    assign mdio = phy_en ? phy_val : 1'bz;

    mdio_master dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .addr       (addr),
        .rd_request (rd_request),
        .wr_request (wr_request),
        .wr_data    (wr_data),
        .ready      (ready),
        .rd_data    (rd_data),
        .mdio_pin   (mdio),
        .mdc_pin    (mdc)
`ifdef MDIO_TA_CHECK_EN
        ,
        .rd_error   (rd_error)
`endif
    );

    // 2.5 MHz clock
    always #200 clock = ~clock;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a request for one clock; inputs are scrambled afterwards to prove capture.
    task automatic start(input logic rd, input logic wr, input logic [4:0] a,
                         input logic [15:0] d);
        addr       = a;
        wr_data    = d;
        rd_request = rd;
        wr_request = wr;
        #1;
        chk1("ready_drop", ready, 1'b0);
        step();
        rd_request = 1'b0;
        wr_request = 1'b0;
        addr       = ~a;
        wr_data    = ~d;
    endtask

    // Walk one frame from the first preamble bit. Stops at the low phase of stop_bit.
    task automatic walk(input logic is_rd, input logic phy_on, input logic [15:0] phy_data,
                        input logic [4:0] a, input logic [15:0] wd, input int stop_bit);
        logic [63:0] exp;
        logic [1:0]  op;
        logic        exp_oe;
        op  = is_rd ? 2'b10 : 2'b01;
        exp = {32'hffff_ffff, 2'b01, op, 5'h00, a, 2'b10, wd};
        for (int b = 0; b < 64; b++) begin
            if (b == stop_bit) return;
            if (phy_on && is_rd && (b >= 47)) begin
                phy_en  = 1'b1;
                phy_val = (b == 47) ? 1'b0 : phy_data[63 - b];
            end
            exp_oe = !(is_rd && (b >= 46));
            chk1("mdc_low", mdc, 1'b0);
            chk1("ready_busy", ready, 1'b0);
            chk1("mdio_oe", dut.mdio_oe, exp_oe);
            if (exp_oe) chk1("mdio_bit", mdio, exp[63 - b]);
            step();
            chk1("mdc_high", mdc, 1'b1);
            chk1("ready_busy_h", ready, 1'b0);
            if (exp_oe) chk1("mdio_bit_h", mdio, exp[63 - b]);
            step();
        end
        phy_en = 1'b0;
        for (int g = 0; g < 4; g++) begin
            chk1("gap_mdc", mdc, 1'b0);
            chk1("gap_ready", ready, 1'b0);
            chk1("gap_oe", dut.mdio_oe, 1'b0);
            step();
        end
        chk1("ready_after", ready, 1'b1);
    endtask

    initial begin
        reset_n    = 1'b0;
        addr       = '0;
        rd_request = 1'b0;
        wr_request = 1'b0;
        wr_data    = '0;
        phy_en     = 1'b0;
        phy_val    = 1'b0;

        // 1: reset held 4 clocks, then release
        repeat (4) step();
        chk1("rst_mdc", mdc, 1'b0);
        chk1("rst_oe", dut.mdio_oe, 1'b0);
        chk16("rst_rd_data", rd_data, 16'h0000);
        chk1("rst_ready", ready, 1'b0);
        reset_n = 1'b1;
        step();
        chk1("rel_ready", ready, 1'b1);
        chk1("rel_mdc", mdc, 1'b0);
        chk1("rel_oe", dut.mdio_oe, 1'b0);
        chk16("rel_rd_data", rd_data, 16'h0000);

        // 2: write addr 09 data 0200
        start(1'b0, 1'b1, 5'h09, 16'h0200);
        walk(1'b0, 1'b0, 16'h0000, 5'h09, 16'h0200, 64);
        chk16("wr_keeps_rd_data", rd_data, 16'h0000);

        // 3: read addr 1f, PHY returns 0160
        start(1'b1, 1'b0, 5'h1f, 16'h0000);
        walk(1'b1, 1'b1, 16'h0160, 5'h1f, 16'h0000, 64);
        chk16("rd_data_0160", rd_data, 16'h0160);
`ifdef MDIO_TA_CHECK_EN
        chk1("rd_error_ok", rd_error, 1'b0);
`endif

        // 4: simultaneous read and write -> read only
        start(1'b1, 1'b1, 5'h03, 16'hbeef);
        walk(1'b1, 1'b1, 16'ha5c3, 5'h03, 16'h0000, 64);
        chk16("both_rd_data", rd_data, 16'ha5c3);
        for (int i = 0; i < 6; i++) begin
            chk1("no_wr_mdc", mdc, 1'b0);
            chk1("no_wr_ready", ready, 1'b1);
            step();
        end

        // 5: reset during DATA bit 8 of a read
        start(1'b1, 1'b0, 5'h11, 16'h0000);
        walk(1'b1, 1'b1, 16'h7e81, 5'h11, 16'h0000, 56);
        reset_n = 1'b0;
        #1;
        chk1("mid_rst_ready", ready, 1'b0);
        step();
        phy_en = 1'b0;
        chk1("abort_mdc", mdc, 1'b0);
        chk1("abort_oe", dut.mdio_oe, 1'b0);
        chk16("abort_rd_data", rd_data, 16'h0000);
        reset_n = 1'b1;
        #1;
        chk1("abort_ready", ready, 1'b1);
        start(1'b0, 1'b1, 5'h0a, 16'h1357);
        walk(1'b0, 1'b0, 16'h0000, 5'h0a, 16'h1357, 64);
        chk16("post_abort_rd_data", rd_data, 16'h0000);

`ifdef MDIO_TA_CHECK_EN
        // 6: absent PHY flags rd_error and keeps rd_data
        start(1'b1, 1'b0, 5'h02, 16'h0000);
        walk(1'b1, 1'b1, 16'h1234, 5'h02, 16'h0000, 64);
        chk16("pre_rd_data", rd_data, 16'h1234);
        chk1("pre_rd_error", rd_error, 1'b0);
        start(1'b1, 1'b0, 5'h02, 16'h0000);
        walk(1'b1, 1'b0, 16'h0000, 5'h02, 16'h0000, 64);
        chk1("absent_rd_error", rd_error, 1'b1);
        chk16("absent_rd_data", rd_data, 16'h1234);
        start(1'b0, 1'b1, 5'h04, 16'h00ff);
        walk(1'b0, 1'b0, 16'h0000, 5'h04, 16'h00ff, 64);
        chk1("wr_keeps_rd_error", rd_error, 1'b1);
        start(1'b1, 1'b0, 5'h02, 16'h0000);
        walk(1'b1, 1'b1, 16'h00ff, 5'h02, 16'h0000, 64);
        chk1("recover_rd_error", rd_error, 1'b0);
        chk16("recover_rd_data", rd_data, 16'h00ff);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
